// File: rtl/sram_pkg.sv
// Shared types and constants for the single-bit SRAM cell: strobe-event
// decode enum, reset value of the stored bit, and the event decode helper.
package sram_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RW    = 2'b11
  } sram_op_e;

  localparam logic SRAM_RST_BIT = 1'b0;

  // Qualified read/write events map straight onto the enum encoding.
  function automatic sram_op_e decode_op(input logic rd_ev, input logic wr_ev);
    return sram_op_e'({wr_ev, rd_ev});
  endfunction

endpackage

// File: rtl/sram_pulse_edge.sv
// 1-bit rising-edge detector: registers the previous strobe sample and flags
// a 0->1 transition in the current cycle.
module sram_pulse_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic rise
);

  logic prev_reg;

  // History updates every cycle regardless of word line, so a held strobe fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= 1'b0;
    else        prev_reg <= pulse;
  end

  assign rise = pulse & ~prev_reg;

endmodule

// File: rtl/sram_cell.sv
// Single-bit SRAM cell with differential write bit lines and a sense-latched
// read output. Define SRAM_CELL_ERR_EN to add the sticky protocol error flag err.
module sram_cell
  import sram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic WL,
  input  logic BL1in,
  input  logic BL2in,
  input  logic read_pulse,
  input  logic write_pulse,
  output logic BL1out
`ifdef SRAM_CELL_ERR_EN
  ,
  output logic err
`endif
);

  logic     rd_rise;
  logic     wr_rise;
  logic     do_read;
  logic     do_write;
  logic     bl_driven;
  logic     q_reg;
  sram_op_e op;

  sram_pulse_edge u_rd_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (read_pulse),
    .rise  (rd_rise)
  );

  sram_pulse_edge u_wr_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .pulse (write_pulse),
    .rise  (wr_rise)
  );

  assign op        = decode_op(rd_rise & WL, wr_rise & WL);
  assign bl_driven = BL1in ^ BL2in;

  always_comb begin
    do_read  = 1'b0;
    do_write = 1'b0;
    unique case (op)
      OP_READ:  do_read = 1'b1;
      OP_WRITE: do_write = 1'b1;
      OP_RW: begin
        do_read  = 1'b1;
        do_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Equal bit-line levels (precharged 1/1 or illegal 0/0) leave the cell untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     q_reg <= SRAM_RST_BIT;
    else if (do_write && bl_driven) q_reg <= BL1in;
  end

  // Sense latch samples the pre-write value, giving read-before-write on OP_RW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       BL1out <= SRAM_RST_BIT;
    else if (do_read) BL1out <= q_reg;
  end

`ifdef SRAM_CELL_ERR_EN
  logic bl_illegal;

  assign bl_illegal = ~BL1in & ~BL2in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if ((op == OP_RW) || (do_write && bl_illegal)) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sram_cell.sv
// Directed testbench for sram_cell; err checks are compiled in when
// SRAM_CELL_ERR_EN is defined.
`timescale 1ns/1ps
module tb_sram_cell;

  logic clk;
  logic rst_n;
  logic WL;
  logic BL1in;
  logic BL2in;
  logic read_pulse;
  logic write_pulse;
  logic BL1out;
`ifdef SRAM_CELL_ERR_EN
  logic err;
`endif

  int checks;
  int errors;

  sram_cell dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .WL          (WL),
    .BL1in       (BL1in),
    .BL2in       (BL2in),
    .read_pulse  (read_pulse),
    .write_pulse (write_pulse),
    .BL1out      (BL1out)
`ifdef SRAM_CELL_ERR_EN
    ,
    .err         (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic b1, input logic b2);
    BL1in = b1; BL2in = b2; write_pulse = 1'b1;
    tick();
    write_pulse = 1'b0;
    tick();
  endtask

  task automatic do_read(output logic val);
    read_pulse = 1'b1;
    tick();
    val = BL1out;
    read_pulse = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; WL = 1'b0; BL1in = 1'b1; BL2in = 1'b1;
    read_pulse = 1'b0; write_pulse = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic v;
    rst_n = 1'b0; WL = 1'b0; BL1in = 1'b1; BL2in = 1'b1;
    read_pulse = 1'b0; write_pulse = 1'b0;
    tick();
    tick();
    checks++;
    if (BL1out !== 1'b0) begin errors++; $display("FAIL reset_bl1out: got %b expected 0", BL1out); end
`ifdef SRAM_CELL_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
`endif
    rst_n = 1'b1;
    tick();
    WL = 1'b1;
    do_read(v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", v); end
    $display("test_reset: read after reset BL1out=%b", v);
  endtask

  task automatic test_write_read();
    logic v;
    WL = 1'b1;
    do_write(1'b1, 1'b0);
    do_read(v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL write1_read: got %b expected 1", v); end
    $display("test_write_read: wrote 1, read %b", v);
  endtask

  task automatic test_back_to_back();
    WL = 1'b1;
    BL1in = 1'b0; BL2in = 1'b1; write_pulse = 1'b1;
    tick();
    write_pulse = 1'b0; read_pulse = 1'b1;
    tick();
    checks++;
    if (BL1out !== 1'b0) begin errors++; $display("FAIL b2b_read0: got %b expected 0", BL1out); end
    read_pulse = 1'b0;
    tick();
    BL1in = 1'b1; BL2in = 1'b0; write_pulse = 1'b1;
    tick();
    write_pulse = 1'b0; read_pulse = 1'b1;
    tick();
    checks++;
    if (BL1out !== 1'b1) begin errors++; $display("FAIL b2b_read1: got %b expected 1", BL1out); end
    read_pulse = 1'b0;
    tick();
    $display("test_back_to_back: write then read on next edge BL1out=%b", BL1out);
  endtask

  task automatic test_undriven_bitlines();
    logic v;
    WL = 1'b1;
    do_write(1'b1, 1'b1);
    do_read(v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL precharge_keep1: got %b expected 1", v); end
    do_write(1'b0, 1'b0);
    do_read(v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL illegal_keep1: got %b expected 1", v); end
`ifdef SRAM_CELL_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", err); end
`endif
    do_write(1'b0, 1'b1);
    do_write(1'b1, 1'b1);
    do_read(v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL precharge_keep0: got %b expected 0", v); end
    $display("test_undriven_bitlines: last read %b", v);
  endtask

  task automatic test_held_strobe();
    logic v;
    WL = 1'b1;
    write_pulse = 1'b1;
    for (int i = 0; i < 4; i++) begin
      BL1in = (i % 2 == 0);
      BL2in = ~BL1in;
      tick();
    end
    write_pulse = 1'b0;
    tick();
    do_read(v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL held_write: got %b expected 1", v); end
    $display("test_held_strobe: held write stored %b", v);
  endtask

  task automatic test_read_write_same_edge();
    logic v;
    apply_reset();
`ifdef SRAM_CELL_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rw_err_clear: got %b expected 0", err); end
`endif
    WL = 1'b1;
    do_write(1'b1, 1'b0);
    BL1in = 1'b0; BL2in = 1'b1; write_pulse = 1'b1; read_pulse = 1'b1;
    tick();
    checks++;
    if (BL1out !== 1'b1) begin errors++; $display("FAIL rw_old_value: got %b expected 1", BL1out); end
    write_pulse = 1'b0; read_pulse = 1'b0;
    tick();
    do_read(v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL rw_new_value: got %b expected 0", v); end
`ifdef SRAM_CELL_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL rw_err: got %b expected 1", err); end
`endif
    $display("test_read_write_same_edge: follow-up read %b", v);
  endtask

  task automatic test_wl_low();
    logic v;
    // Stored 0, latch 0: write with WL=0, keep strobe high while WL rises.
    WL = 1'b0;
    BL1in = 1'b1; BL2in = 1'b0; write_pulse = 1'b1;
    tick();
    WL = 1'b1;
    tick();
    write_pulse = 1'b0;
    tick();
    do_read(v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL wl_low_write: got %b expected 0", v); end
    do_write(1'b1, 1'b0);
    WL = 1'b0;
    do_read(v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL wl_low_read: got %b expected 0", v); end
    WL = 1'b1;
    do_read(v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL wl_high_read: got %b expected 1", v); end
    $display("test_wl_low: final read %b", v);
  endtask

  task automatic test_reset_mid();
    logic v;
    // Stored 1, latch 1. Drop reset mid-cycle while a write of 1 is pending.
    WL = 1'b1;
    BL1in = 1'b1; BL2in = 1'b0; write_pulse = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (BL1out !== 1'b0) begin errors++; $display("FAIL async_reset: got %b expected 0", BL1out); end
`ifdef SRAM_CELL_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL async_reset_err: got %b expected 0", err); end
`endif
    tick();
    write_pulse = 1'b0;
    tick();
    do_read(v);
    checks++;
    if (v !== 1'b0) begin errors++; $display("FAIL reset_q_cleared: got %b expected 0", v); end
    // Strobe already high when reset releases fires on the first edge.
    rst_n = 1'b0;
    write_pulse = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    write_pulse = 1'b0;
    tick();
    do_read(v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL release_strobe_fires: got %b expected 1", v); end
    $display("test_reset_mid: read after release %b", v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_undriven_bitlines();
    test_held_strobe();
    test_read_write_same_edge();
    test_wl_low();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
